// File: rtl/alu_seq_if.sv
// Instruction, external-ALU and debug signals for alu_seq.
// The slave side is the sequencer; the master side is the instruction source plus ALU.
interface alu_seq_if #(
  parameter int DW = 4
);
  logic [8:0]    instr;
  logic          instr_valid;
  logic          instr_ready;
  logic [DW-1:0] alu_in1;
  logic [DW-1:0] alu_in2;
  logic [2:0]    alu_sel;
  logic [DW-1:0] alu_out;
  logic          done;
  logic [DW-1:0] result;
  logic          zero;
  logic [1:0]    dbg_addr;
  logic [DW-1:0] dbg_data;

  modport slave (
    input  instr, instr_valid, alu_out, dbg_addr,
    output instr_ready, alu_in1, alu_in2, alu_sel, done, result, zero, dbg_data
  );

  modport master (
    output instr, instr_valid, alu_out, dbg_addr,
    input  instr_ready, alu_in1, alu_in2, alu_sel, done, result, zero, dbg_data
  );
endinterface

// File: rtl/alu_seq.sv
// Three-state instruction sequencer driving an external combinational ALU.
// Four DW-bit registers; one instruction per IDLE -> EXEC -> WB round trip.
module alu_seq #(
  parameter int DW = 4
) (
  input  logic     clk,
  input  logic     rst,
  alu_seq_if.slave bus
);

  localparam logic [2:0] OP_LDI = 3'b110;
  localparam logic [2:0] OP_NOP = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic          ready;
  logic          vld_p1;
  logic          vld_p2;
  logic          accept;

  logic [DW-1:0] regs [4];
  logic [DW-1:0] alu_in1_p1;
  logic [DW-1:0] alu_in2_p1;
  logic [2:0]    alu_sel_p1;
  logic [2:0]    op_p1;
  logic [1:0]    rd_p1;
  logic [DW-1:0] result_p2;
  logic          zero_p2;

  logic [2:0]    op_f;
  logic [1:0]    rd_f;
  logic [1:0]    rs1_f;
  logic [1:0]    rs2_f;

  function automatic logic [DW-1:0] imm_ext(input logic [3:0] imm);
    return DW'(imm);
  endfunction

  assign op_f   = bus.instr[8:6];
  assign rd_f   = bus.instr[5:4];
  assign rs1_f  = bus.instr[3:2];
  assign rs2_f  = bus.instr[1:0];
  assign accept = bus.instr_valid && ready;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = EXEC;
      EXEC:    state_d = WB;
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ready  = 1'b0;
    vld_p1 = 1'b0;
    vld_p2 = 1'b0;
    case (state_q)
      IDLE:    ready  = 1'b1;
      EXEC:    vld_p1 = 1'b1;
      WB:      vld_p2 = 1'b1;
      default: ready  = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) regs[i] <= '0;
      alu_in1_p1 <= '0;
      alu_in2_p1 <= '0;
      alu_sel_p1 <= '0;
      op_p1      <= OP_NOP;
      rd_p1      <= '0;
      result_p2  <= '0;
      zero_p2    <= 1'b1;
    end else begin
      // Stage 1: operands captured at the handshake, so rd==rs reads the old value.
      if (accept) begin
        op_p1 <= op_f;
        rd_p1 <= rd_f;
        case (op_f)
          OP_LDI: begin
            alu_in1_p1 <= imm_ext(bus.instr[3:0]);
            alu_in2_p1 <= '0;
            alu_sel_p1 <= 3'b000;
          end
          OP_NOP: begin
            alu_in1_p1 <= '0;
            alu_in2_p1 <= '0;
            alu_sel_p1 <= 3'b000;
          end
          default: begin
            alu_in1_p1 <= regs[rs1_f];
            alu_in2_p1 <= regs[rs2_f];
            alu_sel_p1 <= op_f;
          end
        endcase
      end
      // Stage 2: write-back of the external ALU result at the end of EXEC.
      if (vld_p1 && op_p1 != OP_NOP) begin
        regs[rd_p1] <= bus.alu_out;
        result_p2   <= bus.alu_out;
        zero_p2     <= (bus.alu_out == '0);
      end
    end
  end

  assign bus.instr_ready = ready;
  assign bus.done        = vld_p2;
  assign bus.alu_in1     = alu_in1_p1;
  assign bus.alu_in2     = alu_in2_p1;
  assign bus.alu_sel     = alu_sel_p1;
  assign bus.result      = result_p2;
  assign bus.zero        = zero_p2;
  assign bus.dbg_data    = regs[bus.dbg_addr];

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 The module SHALL have one parameter: DW, default 4, the data width of registers and ALU operands; all values below assume DW=4.
REQ-002 The module SHALL have port clk, input, 1, the single rising-edge clock.
REQ-003 The module SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 The module SHALL have port instr, input, 9, the instruction: [8:6] op, [5:4] rd, [3:2] rs1, [1:0] rs2.
REQ-005 The module SHALL have port instr_valid, input, 1, asserted while instr holds a valid instruction.
REQ-006 The module SHALL have port instr_ready, output, 1, high when an instruction can be accepted.
REQ-007 The module SHALL have ports alu_in1 and alu_in2, each output, DW, the operands to the external combinational ALU.
REQ-008 The module SHALL have port alu_sel, output, 3, the ALU operation select.
REQ-009 The module SHALL have port alu_out, input, DW, the ALU result; it is combinational from alu_in1, alu_in2 and alu_sel.
REQ-010 The module SHALL have port done, output, 1, a one-cycle completion pulse.
REQ-011 The module SHALL have port result, output, DW, the last written-back value.
REQ-012 The module SHALL have port zero, output, 1, set when the last written-back value equals 0.
REQ-013 The module SHALL have ports dbg_addr, input, 2, and dbg_data, output, DW; dbg_data combinationally returns register dbg_addr.

Function
REQ-014 The module SHALL contain four DW-bit registers, R0 to R3.
REQ-015 Op codes SHALL be decoded as 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 NOT (of rs1), 110 LDI, 111 NOP.
REQ-016 The FSM SHALL have three states, IDLE, EXEC and WB, with transitions IDLE->EXEC on handshake, EXEC->WB always, and WB->IDLE always.
REQ-017 instr_ready SHALL equal 1 only in IDLE; a handshake is instr_valid AND instr_ready at a rising edge.
REQ-018 instr_valid outside IDLE SHALL be ignored, with no latching and no state change.
REQ-019 On the handshake edge, the module SHALL register alu_in1 = R[rs1], alu_in2 = R[rs2] and alu_sel = op, and latch rd and op.
REQ-020 For LDI, the handshake edge SHALL instead register alu_in1 = {instr[3:0]} zero-extended to DW, alu_in2 = 0 and alu_sel = 000.
REQ-021 For NOP, the handshake edge SHALL instead register alu_in1 = 0, alu_in2 = 0 and alu_sel = 000.
REQ-022 alu_in1, alu_in2 and alu_sel SHALL hold their values in EXEC, WB and IDLE until the next handshake.
REQ-023 On the edge ending EXEC, for every op except NOP, the module SHALL write R[rd] <= alu_out and result <= alu_out, and set zero <= (alu_out == 0).
REQ-024 On the edge ending EXEC, NOP SHALL leave R[rd], result and zero unchanged.
REQ-025 done SHALL be 1 exactly during the WB cycle, for every op including NOP.
REQ-026 Latency SHALL be fixed: handshake at edge k, write-back at edge k+1, done high between edges k+1 and k+2, and next acceptance possible at edge k+3.
REQ-027 Arithmetic SHALL wrap modulo 2^DW and is performed by the external ALU; this block SHALL NOT compute or check results itself.
REQ-028 An instruction with rd equal to rs1 or rs2 SHALL read the pre-write values, since operands are captured at the handshake edge.
REQ-029 A write-back SHALL be visible on dbg_data in the cycle after the writing edge.
REQ-030 An instruction presented continuously SHALL be accepted once per 3 cycles, once each time the FSM is in IDLE.

Reset
REQ-031 While rst is 1 at a rising edge, the module SHALL set state to IDLE, R0 to R3 to 0, alu_in1, alu_in2 and alu_sel to 0, result to 0, zero to 1, done to 0, and instr_ready to 1 in the following cycle.
REQ-032 A reset in EXEC or WB SHALL abort the instruction with no register write and no done pulse.
REQ-033 When rst and instr_valid are both 1 at the same edge, reset SHALL win and the instruction SHALL NOT be accepted.

Verification
REQ-034 The bench SHALL apply reset, then LDI R1,#4 and LDI R2,#9, then ADD R3,R1,R2, and SHALL observe result=1101, zero=0 and dbg_data(R3)=1101.
REQ-035 The bench SHALL execute LDI R0,#9, LDI R1,#1, SUB R2,R0,R1 and SUB R3,R1,R0, and SHALL observe R2=1000 and R3=1000 (wrap).
REQ-036 The bench SHALL execute AND, OR, XOR and NOT on operands 1010/1001, 0100/0101, 0110/0101 and 0110, and SHALL observe 1000, 0101, 0011 and 1001 respectively.
REQ-037 The bench SHALL execute XOR R1,R1,R1 with R1=0110, and SHALL observe R1=0000, zero=1, and operands read before the write.
REQ-038 The bench SHALL hold instr_valid=1 for 9 cycles with a NOP, and SHALL observe exactly 3 done pulses, instr_ready low during EXEC and WB, and registers unchanged.
REQ-039 The bench SHALL assert rst during the EXEC cycle of an ADD into R2=0111, and SHALL observe no done pulse, R2=0000 after reset, and instr_ready=1 on the next cycle.
